// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register for the five-stage LEGv8 core.
//
// Registers the decoded instruction from ID into EX. It also handles:
//   * load-use hazard detection against the instruction currently in EX,
//   * bubble insertion (on a hazard, a flush, or an empty ID slot),
//   * a freeze of the whole stage while data memory is busy,
//   * a saturating count of inserted load-use bubbles.
//
// A bubble carries XZR (31) in every register field. The forwarding unit
// therefore never matches a bubble.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs1/id_rs2/id_rd         decoded register numbers
//   id_use_rs1/id_use_rs2       the instruction really reads rs1 / rs2
//   id_regWrite/id_memRead/id_memWrite  decoded control bits
//   id_rd1/id_rd2/id_imm        operands and sign-extended immediate
//   id_ctrl                     opaque EX/MEM/WB control bundle
//   flush                       branch taken in MEM: squash the entering insn
//   mem_wait                    data memory busy: freeze the stage
//   cnt_clear                   synchronous clear of stall_count
//   stall_if_id                 hold the PC and IF/ID this cycle
//   ex_*                        registered copies of the id_* fields
//   stall_count                 load-use bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_wait,
  input  logic              cnt_clear,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  localparam ex_t BUBBLE = '{rs1: XZR, rs2: XZR, rd: XZR, default: '0};

  ex_t             ex_q;
  ex_t             ex_d;
  logic            hazard;
  logic            count_inc;
  logic [CNT_W-1:0] count_q;

  // Only a load sitting in EX can stall ID. Older producers are handled by
  // forwarding. A load that targets XZR never produces a value to wait for.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != XZR) && id_valid &&
                  ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    ex_d        = ex_q;
    stall_if_id = 1'b0;
    count_inc   = 1'b0;
    if (mem_wait) begin
      // Full freeze. A pending flush is re-presented once memory is ready.
      stall_if_id = 1'b1;
    end else if (flush) begin
      // IF/ID is squashed upstream, so there is nothing to hold there.
      ex_d = BUBBLE;
    end else if (hazard) begin
      ex_d        = BUBBLE;
      stall_if_id = 1'b1;
      count_inc   = 1'b1;
    end else if (id_valid) begin
      ex_d = '{valid:     1'b1,
               reg_write: id_regWrite,
               mem_read:  id_memRead,
               mem_write: id_memWrite,
               rs1:       id_rs1,
               rs2:       id_rs2,
               rd:        id_rd,
               rd1:       id_rd1,
               rd2:       id_rd2,
               imm:       id_imm,
               ctrl:      id_ctrl};
    end else begin
      ex_d = BUBBLE;
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples its pre-edge value, regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_q <= BUBBLE;
    else        ex_q <= ex_d;
  end

  // The clear wins over an increment in the same cycle. The whole counter
  // is frozen with the rest of the stage during mem_wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!mem_wait) begin
      if (cnt_clear)                       count_q <= '0;
      else if (count_inc && count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regWrite = ex_q.reg_write;
  assign ex_memRead  = ex_q.mem_read;
  assign ex_memWrite = ex_q.mem_write;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_ctrl     = ex_q.ctrl;
  assign stall_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// A small 4-bit stall counter makes saturation reachable. Each cycle is
// scored against a behavioural model. Directed vectors also carry
// hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W  = 64;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, rw, mr, mw;
    logic [63:0] rd1, rd2, imm;
    logic [7:0]  ctrl;
    logic        flush, mwait, clr;
  } stim_t;

  typedef struct {
    logic        valid, rw, mr, mw;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rd1, rd2, imm;
    logic [7:0]  ctrl;
  } exr_t;

  // Directed vector: stimulus plus hand-derived expectations.
  typedef struct {
    stim_t      s;
    logic       stall;
    logic       v;
    logic [4:0] rs1, rd;
    int         cnt;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_regWrite, id_memRead, id_memWrite;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic flush, mem_wait, cnt_clear;
  logic stall_if_id, ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  exr_t m_ex;       // model of the EX-stage contents
  int   m_cnt;      // model of the stall counter
  logic last_stall; // stall_if_id sampled in the most recent cycle

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .mem_wait(mem_wait), .cnt_clear(cnt_clear),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exr_t bubble();
    exr_t b;
    b = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, rs1: 5'd31, rs2: 5'd31, rd: 5'd31,
          rd1: 64'd0, rd2: 64'd0, imm: 64'd0, ctrl: 8'd0};
    return b;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // An instruction in ID with random operand data and no control inputs.
  function automatic stim_t ins(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic u1, logic u2, logic rw, logic mr, logic mw);
    stim_t s;
    s.valid = v;  s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.use1 = u1;  s.use2 = u2; s.rw = rw; s.mr = mr; s.mw = mw;
    s.rd1 = rnd64(); s.rd2 = rnd64(); s.imm = rnd64(); s.ctrl = 8'($urandom);
    s.flush = 1'b0; s.mwait = 1'b0; s.clr = 1'b0;
    return s;
  endfunction

  function automatic vec_t vec(stim_t s, logic st, logic v, logic [4:0] rs1, logic [4:0] rd, int cnt);
    vec_t t;
    t.s = s; t.stall = st; t.v = v; t.rs1 = rs1; t.rd = rd; t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    id_regWrite = s.rw; id_memRead = s.mr; id_memWrite = s.mw;
    id_rd1 = s.rd1; id_rd2 = s.rd2; id_imm = s.imm; id_ctrl = s.ctrl;
    flush = s.flush; mem_wait = s.mwait; cnt_clear = s.clr;
  endtask

  task automatic compare_ex(input string tag);
    check({tag, ".ex_valid"},    ex_valid,    m_ex.valid);
    check({tag, ".ex_regWrite"}, ex_regWrite, m_ex.rw);
    check({tag, ".ex_memRead"},  ex_memRead,  m_ex.mr);
    check({tag, ".ex_memWrite"}, ex_memWrite, m_ex.mw);
    check({tag, ".ex_rs1"},      ex_rs1,      m_ex.rs1);
    check({tag, ".ex_rs2"},      ex_rs2,      m_ex.rs2);
    check({tag, ".ex_rd"},       ex_rd,       m_ex.rd);
    check({tag, ".ex_rd1"},      ex_rd1,      m_ex.rd1);
    check({tag, ".ex_rd2"},      ex_rd2,      m_ex.rd2);
    check({tag, ".ex_imm"},      ex_imm,      m_ex.imm);
    check({tag, ".ex_ctrl"},     ex_ctrl,     m_ex.ctrl);
    check({tag, ".stall_count"}, stall_count, m_cnt);
  endtask

  // One clock cycle, entered just after a falling edge. The stall
  // decision is scored before the edge and the new state after it.
  task automatic run_cycle(input stim_t s, input string tag);
    bit load_in_ex, depends, haz, exp_stall;
    drive(s);
    #1;
    load_in_ex = m_ex.valid && m_ex.mr && m_ex.rd != 5'd31;
    depends    = (s.use1 && s.rs1 == m_ex.rd) || (s.use2 && s.rs2 == m_ex.rd);
    haz        = load_in_ex && s.valid && depends;
    exp_stall  = s.mwait || (!s.flush && haz);
    last_stall = stall_if_id;
    check({tag, ".stall_if_id"}, stall_if_id, exp_stall);
    @(posedge clk);
    if (!s.mwait) begin
      if (s.flush || haz || !s.valid) begin
        m_ex = bubble();
      end else begin
        m_ex = '{valid: 1'b1, rw: s.rw, mr: s.mr, mw: s.mw, rs1: s.rs1, rs2: s.rs2,
                 rd: s.rd, rd1: s.rd1, rd2: s.rd2, imm: s.imm, ctrl: s.ctrl};
      end
      if (s.clr)                      m_cnt = 0;
      else if (haz && !s.flush)       m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    #1;
    compare_ex(tag);
    @(negedge clk);
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0:       return 5'd1;
      1:       return 5'd2;
      2:       return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    vec_t  tbl[$];
    stim_t ld, add, ld31, add31, cbz, nop, t;

    // Reset held low with random ID-side activity.
    m_ex = bubble(); m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      t = ins(1'b1, rreg(), rreg(), rreg(), 1'b1, 1'b1, 1'b1, 1'b1, 1'($urandom));
      t.flush = 1'($urandom);
      drive(t);
      @(negedge clk);
      check("reset.stall_if_id", stall_if_id, 1'b0);
      compare_ex("reset");
    end
    reset = 1'b1;

    // LDUR X2,[X1,#0] / ADD X3,X2,X4 / LDUR X31,[X1] / ADD X3,X31,X4 / CBZ X5.
    ld    = ins(1, 5'd1,  5'd31, 5'd2,  1, 0, 1, 1, 0);
    add   = ins(1, 5'd2,  5'd4,  5'd3,  1, 1, 1, 0, 0);
    ld31  = ins(1, 5'd1,  5'd31, 5'd31, 1, 0, 1, 1, 0);
    add31 = ins(1, 5'd31, 5'd4,  5'd3,  1, 1, 1, 0, 0);
    cbz   = ins(1, 5'd2,  5'd5,  5'd31, 0, 1, 0, 0, 0);
    nop   = ins(0, 5'd2,  5'd2,  5'd2,  1, 1, 1, 1, 1);

    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  0));  // captured right after reset
    tbl.push_back(vec(add,   1, 0, 5'd31, 5'd31, 1));  // load-use: bubble
    tbl.push_back(vec(add,   0, 1, 5'd2,  5'd3,  1));  // ADD enters EX
    tbl.push_back(vec(ld31,  0, 1, 5'd1,  5'd31, 1));
    tbl.push_back(vec(add31, 0, 1, 5'd31, 5'd3,  1));  // XZR load: no stall
    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  1));
    tbl.push_back(vec(cbz,   0, 1, 5'd2,  5'd31, 1));  // rs1 match but unused
    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  1));
    t = add; t.flush = 1;
    tbl.push_back(vec(t,     0, 0, 5'd31, 5'd31, 1));  // flush beats hazard
    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  1));
    t = add; t.flush = 1; t.mwait = 1;
    for (int i = 0; i < 3; i++)
      tbl.push_back(vec(t,   1, 1, 5'd1,  5'd2,  1));  // frozen
    t = add; t.flush = 1;
    tbl.push_back(vec(t,     0, 0, 5'd31, 5'd31, 1));  // flush after the freeze
    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  1));
    t = add; t.clr = 1;
    tbl.push_back(vec(t,     1, 0, 5'd31, 5'd31, 0));  // clear beats increment
    tbl.push_back(vec(add,   0, 1, 5'd2,  5'd3,  0));
    tbl.push_back(vec(nop,   0, 0, 5'd31, 5'd31, 0));  // empty ID slot
    tbl.push_back(vec(ld,    0, 1, 5'd1,  5'd2,  0));
    tbl.push_back(vec(add,   1, 0, 5'd31, 5'd31, 1));
    t = nop; t.mwait = 1; t.clr = 1;
    tbl.push_back(vec(t,     1, 0, 5'd31, 5'd31, 1));  // clear ignored while frozen
    t = nop; t.clr = 1;
    tbl.push_back(vec(t,     0, 0, 5'd31, 5'd31, 0));

    foreach (tbl[i]) begin
      run_cycle(tbl[i].s, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.stall", i),   last_stall,  tbl[i].stall);
      check($sformatf("vec%0d.valid", i),   ex_valid,    tbl[i].v);
      check($sformatf("vec%0d.rs1", i),     ex_rs1,      tbl[i].rs1);
      check($sformatf("vec%0d.rd", i),      ex_rd,       tbl[i].rd);
      check($sformatf("vec%0d.count", i),   stall_count, tbl[i].cnt);
    end

    // Saturation: 20 load-use stalls into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      run_cycle(ld, "sat.ld");
      run_cycle(add, "sat.add");
    end
    check("sat.count_is_15", stall_count, 15);
    run_cycle(ld, "satclr.ld");
    t = add; t.clr = 1;
    run_cycle(t, "satclr.add");
    check("satclr.stalled", last_stall, 1'b1);
    check("satclr.count_is_0", stall_count, 0);

    // Randomized traffic with a small register pool, to make hazards common.
    for (int i = 0; i < 2000; i++) begin
      t = ins(($urandom_range(0, 9) < 8), rreg(), rreg(), rreg(), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      t.flush = ($urandom_range(0, 9) == 0);
      t.mwait = ($urandom_range(0, 19) < 3);
      t.clr   = ($urandom_range(0, 19) == 0);
      run_cycle(t, "rand");
    end

    // Reset asserted in the middle of a load-use stall.
    run_cycle(ld, "midrst.ld");
    drive(add);
    #1;
    check("midrst.stall_before", stall_if_id, 1'b1);
    #2 reset = 1'b0;
    #1;
    m_ex = bubble(); m_cnt = 0;
    check("midrst.stall_after", stall_if_id, 1'b0);
    compare_ex("midrst");
    @(negedge clk);
    reset = 1'b1;
    run_cycle(add, "postrst.add");
    check("postrst.captured_rs1", ex_rs1, 5'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage LEGv8 core, with integrated load-use hazard detection, bubble insertion, branch flush and memory-wait freeze.
- Its ex_* register outputs feed the EX-stage forwarding unit (ex_rs1/ex_rs2) and the EX/MEM register.
- Holds a saturating count of inserted load-use bubbles for performance analysis.

Parameters:
- DATA_W, 64, width of register operands and immediate.
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle (ALU op, ALUSrc, MemtoReg, Branch, ...).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register numbers decoded in ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction actually reads rs1 / rs2.
- id_regWrite, id_memRead, id_memWrite  in  1 each  decoded control bits.
- id_rd1, id_rd2, id_imm  in  DATA_W each  register-file read data and sign-extended immediate.
- id_ctrl  in  CTRL_W  remaining control bundle.
- flush  in  1  branch taken in MEM; squash the instruction entering EX.
- mem_wait  in  1  data memory not ready; freeze the stage.
- cnt_clear  in  1  synchronous clear of the stall counter.
- stall_if_id  out  1  hold the PC and IF/ID register this cycle.
- ex_valid, ex_regWrite, ex_memRead, ex_memWrite  out  1 each  registered control bits.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register numbers.
- ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered operands.
- ex_ctrl  out  CTRL_W  registered control bundle.
- stall_count  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (reset=0, asynchronous) sets every ex_* output to 0, except ex_rd, ex_rs1 and ex_rs2, which are set to 31 (XZR). stall_count is set to 0.
- A bubble has ex_valid, ex_regWrite, ex_memRead and ex_memWrite all 0, ex_rd/ex_rs1/ex_rs2=31, and all other fields 0. With XZR in every register field, the forwarding unit can never match a bubble.
- Load-use hazard (combinational) = ex_valid & ex_memRead & ex_rd!=31 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Per-cycle priority, highest first:
  1. mem_wait=1: all ex_* registers hold their values; stall_if_id=1; stall_count does not change; flush is ignored. The flush source holds flush until mem_wait drops.
  2. flush=1: load a bubble; stall_if_id=0, because IF/ID is flushed upstream; stall_count does not change.
  3. hazard=1: load a bubble; stall_if_id=1; stall_count increments by 1 and saturates at all-ones.
  4. Otherwise: capture all id_* inputs into ex_*. If id_valid=0, capture a bubble instead. stall_if_id=0.
- stall_if_id is combinational from current state and inputs, with zero latency. All ex_* outputs have a 1-cycle latency from id_*.
- A load-use stall lasts exactly one cycle, because the inserted bubble clears ex_memRead. Back-to-back loads with dependencies therefore produce one bubble each.
- Sources are compared against ex_rd only. EX/MEM and MEM/WB dependencies are left to the forwarding unit.
- id_rd=31 with id_memRead=1 never triggers a stall.
- cnt_clear=1 sets stall_count to 0 on the next edge. It takes priority over an increment in the same cycle, and is ignored while mem_wait=1.
- Reset asserted mid-stall returns the stage to the reset state immediately. stall_if_id then evaluates to 0, because ex_valid=0.

Test Plan:
- Reset: hold reset=0 with random id_* inputs -> all ex_* outputs 0 except ex_rd=ex_rs1=ex_rs2=31; stall_count=0; stall_if_id=0. Release reset -> the next edge captures id_*.
- Load-use: LDUR X2,[X1,#0] then ADD X3,X2,X4 (id_use_rs1=1, id_rs1=2) -> stall_if_id=1 for exactly one cycle; ex_valid=0 in the following cycle; ADD enters EX one cycle later with ex_rs1=2; stall_count=1.
- No false stall: LDUR X31,[X1] then ADD X3,X31,X4 -> stall_if_id=0. LDUR X2 then CBZ X5 (id_use_rs1=0, id_use_rs2=1, id_rs2=5) -> no stall.
- Flush versus hazard: a load-use condition and flush=1 in the same cycle -> bubble loaded, stall_if_id=0, stall_count unchanged.
- mem_wait: assert for 3 cycles while a load-use condition and flush are both present -> ex_* outputs constant, stall_if_id=1 throughout, stall_count unchanged. When mem_wait deasserts with flush still high -> bubble loaded.
- Counter: force CNT_W=4 and generate 20 load-use stalls -> stall_count saturates at 15. Pulse cnt_clear together with a stall -> stall_count=0.
